// File: rtl/countdown_timer_if.sv
// Button and display bundle for the mm:ss countdown timer.
// The timer sits on the slave side; whoever presses buttons and reads the display is the master.
interface countdown_timer_if;
    logic [3:0]  btn_pedge;  // [0] start/pause, [1] sec+1, [2] min+1, [3] clear
    logic [15:0] value;      // {min10,min1,sec10,sec1} BCD
    logic        running;
    logic        alarm;

    modport master (output btn_pedge, input value, input running, input alarm);
    modport slave  (input btn_pedge, output value, output running, output alarm);
endinterface

// File: rtl/countdown_timer.sv
// Loadable mm:ss countdown (cook) timer with alarm and automatic return to the preset.
// Buttons set minutes/seconds in SET. Start loads the preset and counts down one second per tick.
// 00:00 raises the alarm for ALARM_SEC seconds or until a button press, then restores the preset.
module countdown_timer #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int ALARM_SEC = 10
) (
    input  logic clk,
    input  logic reset_n,
    countdown_timer_if.slave bus
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = $clog2(ALARM_SEC + 1);

    typedef enum logic [1:0] {S_SET, S_RUN, S_PAUSE, S_ALARM} state_t;

    state_t         state_q;
    logic [15:0]    value_q;
    logic [15:0]    preset_q;
    logic [PW-1:0]  presc_q;
    logic [AW-1:0]  asec_q;
    logic           running_q;
    logic           alarm_q;

    logic           tick;
    logic [PW-1:0]  presc_d;
    logic [15:0]    value_inc_d;
    logic [15:0]    value_dec_d;

    // Two-digit BCD increment over 00..59; 59 wraps to 00 with no carry out.
    function automatic logic [7:0] bcd59_inc(input logic [7:0] v);
        if (v == 8'h59)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // mm:ss BCD decrement with borrows; only called on a non-zero value.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] s1, s10, m1, m10;
        s1  = v[3:0];
        s10 = v[7:4];
        m1  = v[11:8];
        m10 = v[15:12];
        if (s1 != 4'd0) begin
            s1 = s1 - 4'd1;
        end else begin
            s1 = 4'd9;
            if (s10 != 4'd0) begin
                s10 = s10 - 4'd1;
            end else begin
                s10 = 4'd5;
                if (m1 != 4'd0) begin
                    m1 = m1 - 4'd1;
                end else begin
                    m1  = 4'd9;
                    m10 = m10 - 4'd1;
                end
            end
        end
        return {m10, m1, s10, s1};
    endfunction

    // Tick detection, prescaler advance and candidate display values.
    always_comb begin
        tick        = (presc_q == PW'(TICK_DIV - 1));
        presc_d     = tick ? '0 : presc_q + 1'b1;
        value_inc_d = {bus.btn_pedge[2] ? bcd59_inc(value_q[15:8]) : value_q[15:8],
                       bus.btn_pedge[1] ? bcd59_inc(value_q[7:0])  : value_q[7:0]};
        value_dec_d = bcd_dec(value_q);
    end

    // Timer FSM; running/alarm are registered alongside the state they mirror.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_SET;
            value_q   <= 16'h0000;
            preset_q  <= 16'h0000;
            presc_q   <= '0;
            asec_q    <= '0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else if (bus.btn_pedge[3]) begin
            state_q   <= S_SET;
            value_q   <= 16'h0000;
            preset_q  <= 16'h0000;
            presc_q   <= '0;
            asec_q    <= '0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            case (state_q)
                S_SET: begin
                    if (bus.btn_pedge[0] && (value_q != 16'h0000)) begin
                        // Increments pressed together with start are dropped.
                        preset_q  <= value_q;
                        presc_q   <= '0;
                        state_q   <= S_RUN;
                        running_q <= 1'b1;
                    end else begin
                        value_q <= value_inc_d;
                    end
                end
                S_RUN: begin
                    // Pause freezes the count, except that a tick landing on it is consumed.
                    if (!bus.btn_pedge[0] || tick)
                        presc_q <= presc_d;
                    if (tick) begin
                        value_q <= value_dec_d;
                    end
                    if (tick && (value_dec_d == 16'h0000)) begin
                        state_q   <= S_ALARM;
                        asec_q    <= '0;
                        running_q <= 1'b0;
                        alarm_q   <= 1'b1;
                    end else if (bus.btn_pedge[0]) begin
                        state_q   <= S_PAUSE;
                        running_q <= 1'b0;
                    end
                end
                S_PAUSE: begin
                    if (bus.btn_pedge[0]) begin
                        state_q   <= S_RUN;
                        running_q <= 1'b1;
                    end
                end
                S_ALARM: begin
                    presc_q <= presc_d;
                    if (tick)
                        asec_q <= asec_q + 1'b1;
                    if ((|bus.btn_pedge[2:0]) || (tick && (asec_q == AW'(ALARM_SEC - 1)))) begin
                        value_q <= preset_q;
                        state_q <= S_SET;
                        alarm_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= S_SET;
                    value_q   <= 16'h0000;
                    running_q <= 1'b0;
                    alarm_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.value   = value_q;
    assign bus.running = running_q;
    assign bus.alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer with TICK_DIV=4, ALARM_SEC=3.
// Expected outputs are queued as each stimulus is applied and checked one cycle (or N cycles) later.
module tb_countdown_timer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    countdown_timer_if bus ();

    countdown_timer #(.TICK_DIV(4), .ALARM_SEC(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] v;
        logic        r;
        logic        a;
    } exp_t;

    typedef struct {
        logic [3:0]  btn;
        logic [15:0] v;
        logic        r;
        logic        a;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[11];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic logic [7:0] to_bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    // Pop the oldest expectation and compare it with what the DUT shows now.
    task automatic check_front(input string nm);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", nm);
            return;
        end
        e = sb_q.pop_front();
        n_cmp++;
        if (bus.value !== e.v || bus.running !== e.r || bus.alarm !== e.a) begin
            n_fail++;
            $display("FAIL %s: got value=%h running=%b alarm=%b, want value=%h running=%b alarm=%b",
                     nm, bus.value, bus.running, bus.alarm, e.v, e.r, e.a);
        end
    endtask

    // One-cycle button pulse, response checked just after the next edge.
    task automatic drive(input logic [3:0] b, input logic [15:0] v, input logic r,
                         input logic a, input string nm);
        sb_q.push_back('{v: v, r: r, a: a});
        bus.btn_pedge = b;
        @(posedge clk);
        #1;
        bus.btn_pedge = 4'h0;
        check_front(nm);
    endtask

    // No buttons for n cycles, then check.
    task automatic idle_chk(input int n, input logic [15:0] v, input logic r,
                            input logic a, input string nm);
        sb_q.push_back('{v: v, r: r, a: a});
        bus.btn_pedge = 4'h0;
        repeat (n) @(posedge clk);
        #1;
        check_front(nm);
    endtask

    // One-cycle reset pulse; every output must read zero afterwards.
    task automatic reset_chk(input string nm);
        sb_q.push_back('{v: 16'h0000, r: 1'b0, a: 1'b0});
        bus.btn_pedge = 4'h0;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_front(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // Set-mode vectors: three min+1, five sec+1, both together, clear, start at zero.
        vecs[0]  = '{btn: 4'b0100, v: 16'h0100, r: 1'b0, a: 1'b0};
        vecs[1]  = '{btn: 4'b0100, v: 16'h0200, r: 1'b0, a: 1'b0};
        vecs[2]  = '{btn: 4'b0100, v: 16'h0300, r: 1'b0, a: 1'b0};
        vecs[3]  = '{btn: 4'b0010, v: 16'h0301, r: 1'b0, a: 1'b0};
        vecs[4]  = '{btn: 4'b0010, v: 16'h0302, r: 1'b0, a: 1'b0};
        vecs[5]  = '{btn: 4'b0010, v: 16'h0303, r: 1'b0, a: 1'b0};
        vecs[6]  = '{btn: 4'b0010, v: 16'h0304, r: 1'b0, a: 1'b0};
        vecs[7]  = '{btn: 4'b0010, v: 16'h0305, r: 1'b0, a: 1'b0};
        vecs[8]  = '{btn: 4'b0110, v: 16'h0406, r: 1'b0, a: 1'b0};
        vecs[9]  = '{btn: 4'b1000, v: 16'h0000, r: 1'b0, a: 1'b0};
        vecs[10] = '{btn: 4'b0001, v: 16'h0000, r: 1'b0, a: 1'b0};

        bus.btn_pedge = 4'h0;
        reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_chk("reset");

        for (int i = 0; i < 11; i++)
            drive(vecs[i].btn, vecs[i].v, vecs[i].r, vecs[i].a, $sformatf("vec%0d", i));

        // Seconds wrap 59 -> 00 without touching minutes.
        for (int i = 1; i <= 59; i++)
            drive(4'b0010, {8'h00, to_bcd(i)}, 1'b0, 1'b0, $sformatf("sec_inc%0d", i));
        drive(4'b0010, 16'h0000, 1'b0, 1'b0, "sec_wrap");
        drive(4'b0110, 16'h0101, 1'b0, 1'b0, "both_inc");
        // Minutes wrap 59 -> 00 keeping seconds.
        for (int m = 2; m <= 59; m++)
            drive(4'b0100, {to_bcd(m), 8'h01}, 1'b0, 1'b0, $sformatf("min_inc%0d", m));
        drive(4'b0100, 16'h0001, 1'b0, 1'b0, "min_wrap");

        // 01:00 counts down with borrows through both digit pairs.
        drive(4'b1000, 16'h0000, 1'b0, 1'b0, "clr3");
        drive(4'b0100, 16'h0100, 1'b0, 1'b0, "load0100");
        drive(4'b0001, 16'h0100, 1'b1, 1'b0, "start0100");
        idle_chk(3, 16'h0100, 1'b1, 1'b0, "pre_tick");
        idle_chk(1, 16'h0059, 1'b1, 1'b0, "tick1_0059");
        idle_chk(4, 16'h0058, 1'b1, 1'b0, "tick2_0058");

        // Alarm then auto-return to preset; start drops a concurrent sec+1.
        drive(4'b1000, 16'h0000, 1'b0, 1'b0, "clr4");
        drive(4'b0010, 16'h0001, 1'b0, 1'b0, "load0001");
        drive(4'b0010, 16'h0002, 1'b0, 1'b0, "load0002");
        drive(4'b0011, 16'h0002, 1'b1, 1'b0, "start_drop_inc");
        idle_chk(4, 16'h0001, 1'b1, 1'b0, "tick_0001");
        idle_chk(4, 16'h0000, 1'b0, 1'b1, "alarm_on");
        idle_chk(11, 16'h0000, 1'b0, 1'b1, "alarm_hold");
        idle_chk(1, 16'h0002, 1'b0, 1'b0, "alarm_timeout");
        // Button press ends the alarm early.
        drive(4'b0001, 16'h0002, 1'b1, 1'b0, "restart");
        idle_chk(8, 16'h0000, 1'b0, 1'b1, "alarm_on2");
        drive(4'b0010, 16'h0002, 1'b0, 1'b0, "alarm_btn_exit");
        // Clear during alarm gives zero, not the preset.
        drive(4'b0001, 16'h0002, 1'b1, 1'b0, "restart2");
        idle_chk(8, 16'h0000, 1'b0, 1'b1, "alarm_on3");
        drive(4'b1000, 16'h0000, 1'b0, 1'b0, "alarm_clear");

        // Pause two cycles into a tick, resume from the held count.
        for (int i = 1; i <= 10; i++)
            drive(4'b0010, {8'h00, to_bcd(i)}, 1'b0, 1'b0, $sformatf("load10_%0d", i));
        drive(4'b0001, 16'h0010, 1'b1, 1'b0, "start0010");
        idle_chk(2, 16'h0010, 1'b1, 1'b0, "two_in");
        drive(4'b0001, 16'h0010, 1'b0, 1'b0, "pause");
        drive(4'b0110, 16'h0010, 1'b0, 1'b0, "pause_ign_inc");
        idle_chk(20, 16'h0010, 1'b0, 1'b0, "pause_hold");
        drive(4'b0001, 16'h0010, 1'b1, 1'b0, "resume");
        drive(4'b0110, 16'h0010, 1'b1, 1'b0, "run_ign_inc");
        idle_chk(1, 16'h0009, 1'b1, 1'b0, "resume_tick");
        // Pause landing exactly on a tick still decrements.
        idle_chk(3, 16'h0009, 1'b1, 1'b0, "before_tick");
        drive(4'b0001, 16'h0008, 1'b0, 1'b0, "pause_on_tick");
        idle_chk(5, 16'h0008, 1'b0, 1'b0, "pause_on_tick_hold");

        // Clear mid-run, reset mid-run, start at zero ignored.
        drive(4'b0001, 16'h0008, 1'b1, 1'b0, "resume2");
        idle_chk(2, 16'h0008, 1'b1, 1'b0, "run_mid");
        drive(4'b1000, 16'h0000, 1'b0, 1'b0, "clear_run");
        drive(4'b0100, 16'h0100, 1'b0, 1'b0, "load_rst");
        drive(4'b0001, 16'h0100, 1'b1, 1'b0, "start_rst");
        idle_chk(2, 16'h0100, 1'b1, 1'b0, "run_before_rst");
        reset_chk("reset_mid_run");
        drive(4'b0001, 16'h0000, 1'b0, 1'b0, "start_zero");
        idle_chk(5, 16'h0000, 1'b0, 1'b0, "stay_set");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
